// File: rtl/uart_rx_fifo.sv
// UART receive capture FSM feeding a first-word fall-through byte FIFO.
// The capture FSM acknowledges each UART byte with a single-cycle pulse and
// waits for the valid level to drop, so a held byte is stored only once.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_rx_data,
    input  logic          in_rx_valid,
    output logic          out_rx_data_is_read,
    input  logic          in_read_en,
    output logic [7:0]    out_data,
    output logic          out_empty,
    output logic          out_full,
    output logic [CW-1:0] out_count,
    output logic          out_overflow,
    input  logic          in_clear_overflow
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ack_next;
    logic          push;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    // Capture FSM state and registered acknowledge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            out_rx_data_is_read <= 1'b0;
        end else begin
            state               <= state_next;
            out_rx_data_is_read <= ack_next;
        end
    end

    // Capture FSM next state; the byte is taken on the IDLE-to-ACK edge
    always_comb begin
        state_next = state;
        push       = 1'b0;
        ack_next   = 1'b0;
        case (state)
            IDLE: begin
                if (in_rx_valid) begin
                    push       = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!in_rx_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pop only when data exists; a push into a full FIFO survives only with a same-cycle pop
    always_comb begin
        pop    = in_read_en && (count != '0);
        accept = push && ((count != FULL_CNT) || pop);
        drop   = push && (count == FULL_CNT) && !pop;
    end

    // Storage write; contents are not reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= in_rx_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (in_clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Status and fall-through head byte
    always_comb begin
        out_data     = mem[rd_ptr];
        out_count    = count;
        out_empty    = (count == '0);
        out_full     = (count == FULL_CNT);
        out_overflow = overflow;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a
// monitor checks every effective pop and every acknowledge pulse.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_rx_data = 8'h00;
    logic       in_rx_valid = 1'b0;
    logic       out_rx_data_is_read;
    logic       in_read_en = 1'b0;
    logic [7:0] out_data;
    logic       out_empty;
    logic       out_full;
    logic [4:0] out_count;
    logic       out_overflow;
    logic       in_clear_overflow = 1'b0;

    int         n_checks = 0;
    int         n_pass = 0;
    int         ack_count = 0;
    int         ack_exp = 0;
    logic       prev_ack = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_fifo #(.DEPTH(16), .CW(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_rx_data          (in_rx_data),
        .in_rx_valid         (in_rx_valid),
        .out_rx_data_is_read (out_rx_data_is_read),
        .in_read_en          (in_read_en),
        .out_data            (out_data),
        .out_empty           (out_empty),
        .out_full            (out_full),
        .out_count           (out_count),
        .out_overflow        (out_overflow),
        .in_clear_overflow   (in_clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Data monitor: every effective pop must present the oldest expected byte
    always @(negedge clk) begin
        if (!reset && in_read_en && !out_empty) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", int'(out_data), -1);
            end else begin
                exp_b = exp_q.pop_front();
                check("pop_data", int'(out_data), int'(exp_b));
            end
        end
    end

    // Acknowledge monitor: pulses are counted and never last two cycles
    always @(negedge clk) begin
        if (out_rx_data_is_read) begin
            check("ack_single_cycle", int'(prev_ack), 0);
            ack_count++;
        end
        prev_ack = out_rx_data_is_read;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_rx_data_is_read) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int extra);
        in_rx_data  = b;
        in_rx_valid = 1'b1;
        wait_ack("ack_seen");
        ack_exp++;
        repeat (extra) tick();
        in_rx_valid = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        in_read_en = 1'b1;
        tick();
        in_read_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_count", int'(out_count), 0);
        check("rst_empty", int'(out_empty), 1);
        check("rst_full", int'(out_full), 0);
        check("rst_overflow", int'(out_overflow), 0);
        check("rst_ack", int'(out_rx_data_is_read), 0);
        reset = 1'b0;
        tick();

        // Single byte
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 0);
        check("single_count", int'(out_count), 1);
        check("single_data", int'(out_data), 8'hA5);
        check("single_not_empty", int'(out_empty), 0);
        check("single_acks", ack_count, 1);
        pop_one();
        check("single_empty_after_pop", int'(out_empty), 1);

        // Read while empty is ignored
        in_read_en = 1'b1;
        tick();
        tick();
        in_read_en = 1'b0;
        check("empty_read_count", int'(out_count), 0);
        check("empty_read_empty", int'(out_empty), 1);

        // Valid held long after the acknowledge
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 10);
        check("held_acks", ack_count, 2);
        check("held_count", int'(out_count), 1);
        pop_one();

        // Push and pop together on an empty FIFO
        exp_q.push_back(8'h7E);
        in_rx_data  = 8'h7E;
        in_rx_valid = 1'b1;
        in_read_en  = 1'b1;
        tick();
        in_read_en  = 1'b0;
        check("empty_pushpop_count", int'(out_count), 1);
        tick();
        in_rx_valid = 1'b0;
        tick();
        ack_exp++;
        pop_one();
        check("empty_pushpop_drained", int'(out_empty), 1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 0);
        end
        check("fill_full", int'(out_full), 1);
        check("fill_count", int'(out_count), 16);
        check("fill_no_overflow", int'(out_overflow), 0);
        send_byte(8'hFF, 0);
        check("drop_overflow", int'(out_overflow), 1);
        check("drop_count", int'(out_count), 16);
        check("drop_acks", ack_count, ack_exp);
        for (int i = 0; i < 16; i++) pop_one();
        check("drain_empty", int'(out_empty), 1);
        check("overflow_sticky", int'(out_overflow), 1);
        in_clear_overflow = 1'b1;
        tick();
        in_clear_overflow = 1'b0;
        check("overflow_cleared", int'(out_overflow), 0);

        // Full FIFO with same-edge push and pop
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send_byte(8'(8'h10 + i), 0);
        end
        exp_q.push_back(8'h55);
        in_rx_data  = 8'h55;
        in_rx_valid = 1'b1;
        in_read_en  = 1'b1;
        tick();
        in_read_en  = 1'b0;
        check("fullpp_ack", int'(out_rx_data_is_read), 1);
        check("fullpp_count", int'(out_count), 16);
        check("fullpp_full", int'(out_full), 1);
        tick();
        in_rx_valid = 1'b0;
        tick();
        ack_exp++;
        check("fullpp_no_overflow", int'(out_overflow), 0);
        for (int i = 0; i < 16; i++) pop_one();
        check("fullpp_empty", int'(out_empty), 1);

        // Streaming with low occupancy so the pointers wrap
        exp_q.push_back(8'h40);
        send_byte(8'h40, 0);
        exp_q.push_back(8'h41);
        send_byte(8'h41, 0);
        for (int i = 2; i < 40; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            send_byte(8'(8'h40 + i), 0);
            check("stream_count_push", int'(out_count), 3);
            pop_one();
            check("stream_count_pop", int'(out_count), 2);
        end
        pop_one();
        pop_one();
        check("stream_empty", int'(out_empty), 1);
        check("stream_acks", ack_count, ack_exp);

        // Drop coinciding with clear: set wins
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            send_byte(8'(8'h80 + i), 0);
        end
        in_rx_data        = 8'hEE;
        in_rx_valid       = 1'b1;
        in_clear_overflow = 1'b1;
        tick();
        in_clear_overflow = 1'b0;
        check("set_wins_overflow", int'(out_overflow), 1);
        tick();
        in_rx_valid = 1'b0;
        tick();
        ack_exp++;
        for (int i = 0; i < 11; i++) pop_one();
        check("pre_reset_count", int'(out_count), 5);
        check("pre_reset_overflow", int'(out_overflow), 1);

        // Reset during WAIT_LOW aborts the handshake; held byte is recaptured once
        in_rx_data  = 8'hC3;
        in_rx_valid = 1'b1;
        tick();
        tick();
        ack_exp++;
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_count", int'(out_count), 0);
        check("midrst_empty", int'(out_empty), 1);
        check("midrst_full", int'(out_full), 0);
        check("midrst_overflow", int'(out_overflow), 0);
        check("midrst_ack", int'(out_rx_data_is_read), 0);
        reset = 1'b0;
        exp_q.push_back(8'hC3);
        wait_ack("recapture_ack");
        ack_exp++;
        repeat (3) tick();
        in_rx_valid = 1'b0;
        tick();
        check("recapture_count", int'(out_count), 1);
        check("recapture_acks", ack_count, ack_exp);
        pop_one();
        check("recapture_empty", int'(out_empty), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
